// File: rtl/change_dispenser_pkg.sv
// Shared types and constants for the change payout path.
// AMT_W is also used by the upstream change calculation stage.
package change_dispenser_pkg;

    localparam int unsigned AMT_W     = 5;
    localparam int unsigned NUM_COINS = 4;

    typedef logic [AMT_W-1:0] amount_t;
    typedef logic [1:0]       coin_t;

    localparam coin_t COIN_10 = 2'd0;
    localparam coin_t COIN_5  = 2'd1;
    localparam coin_t COIN_2  = 2'd2;
    localparam coin_t COIN_1  = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StDispense,
        StFinish
    } state_t;

    function automatic amount_t denom_of(input coin_t c);
        amount_t d;
        case (c)
            COIN_10: d = amount_t'(10);
            COIN_5:  d = amount_t'(5);
            COIN_2:  d = amount_t'(2);
            default: d = amount_t'(1);
        endcase
        return d;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request, hopper handshake and status bundle of the change dispenser.
// master = controlling side (transaction logic / hopper), slave = dispenser.
interface change_dispenser_if #(
    parameter int unsigned STOCK_W = 4
);
    import change_dispenser_pkg::*;

    logic                     start;
    amount_t                  change_amount;
    logic                     refill;
    logic                     coin_ack;
    logic                     coin_req;
    coin_t                    coin_sel;
    logic                     busy;
    logic                     done;
    amount_t                  dispensed_total;
    amount_t                  shortfall;
    logic [4*STOCK_W-1:0]     stock_level;
    logic [3:0]               jammed;

    modport master (
        output start, change_amount, refill, coin_ack,
        input  coin_req, coin_sel, busy, done, dispensed_total, shortfall, stock_level, jammed
    );

    modport slave (
        input  start, change_amount, refill, coin_ack,
        output coin_req, coin_sel, busy, done, dispensed_total, shortfall, stock_level, jammed
    );

endinterface

// File: rtl/change_dispenser_coin_selector.sv
// Greedy coin pick: the largest denomination that fits the remaining amount
// and is both stocked and not jammed.
module change_dispenser_coin_selector
    import change_dispenser_pkg::*;
(
    input  amount_t              remaining,
    input  logic [NUM_COINS-1:0] stock_nz,
    input  logic [NUM_COINS-1:0] jammed,
    output logic                 valid,
    output coin_t                idx
);

    // Scan from the smallest coin upward so the lowest eligible index wins.
    always_comb begin
        valid = 1'b0;
        idx   = COIN_10;
        for (int i = NUM_COINS - 1; i >= 0; i--) begin
            if (stock_nz[i] && !jammed[i] && (denom_of(coin_t'(i)) <= remaining)) begin
                valid = 1'b1;
                idx   = coin_t'(i);
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Pays a latched change amount as single coins over the hopper handshake,
// tracking per-denomination stock, jams, amount paid and shortfall.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int unsigned STOCK_W     = 4,
    parameter int unsigned STOCK_INIT  = 8,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input logic               clk,
    input logic               reset,
    change_dispenser_if.slave bus
);

    localparam int unsigned          CNT_W      = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [STOCK_W-1:0]   STOCK_FULL = STOCK_W'(STOCK_INIT);

    state_t                     state_q;
    amount_t                    remaining_q;
    amount_t                    dispensed_q;
    amount_t                    shortfall_q;
    logic [CNT_W-1:0]           cnt_q;
    coin_t                      coin_sel_q;
    logic                       coin_req_q;
    logic                       busy_q;
    logic                       done_q;
    logic [NUM_COINS-1:0]       jammed_q;
    logic [STOCK_W-1:0]         stock_q [NUM_COINS];

    logic [NUM_COINS-1:0]       stock_nz;
    logic [NUM_COINS*STOCK_W-1:0] stock_level;
    logic                       sel_valid;
    coin_t                      sel_idx;

    always_comb begin
        stock_nz    = '0;
        stock_level = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            stock_nz[i]                         = (stock_q[i] != '0);
            stock_level[i*STOCK_W +: STOCK_W]   = stock_q[i];
        end
    end

    change_dispenser_coin_selector u_sel (
        .remaining (remaining_q),
        .stock_nz  (stock_nz),
        .jammed    (jammed_q),
        .valid     (sel_valid),
        .idx       (sel_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            dispensed_q <= '0;
            shortfall_q <= '0;
            cnt_q       <= '0;
            coin_sel_q  <= COIN_10;
            coin_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            jammed_q    <= '0;
            for (int i = 0; i < NUM_COINS; i++) stock_q[i] <= STOCK_FULL;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        remaining_q <= bus.change_amount;
                        dispensed_q <= '0;
                        shortfall_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= StSelect;
                    end else if (bus.refill) begin
                        jammed_q <= '0;
                        for (int i = 0; i < NUM_COINS; i++) stock_q[i] <= STOCK_FULL;
                    end
                end
                StSelect: begin
                    if (sel_valid) begin
                        coin_sel_q <= sel_idx;
                        cnt_q      <= '0;
                        coin_req_q <= 1'b1;
                        state_q    <= StDispense;
                    end else begin
                        // Shortfall is registered here so it is valid alongside done.
                        shortfall_q <= remaining_q;
                        done_q      <= 1'b1;
                        state_q     <= StFinish;
                    end
                end
                StDispense: begin
                    // Ack takes precedence over a timeout expiring in the same cycle.
                    if (bus.coin_ack) begin
                        remaining_q <= remaining_q - denom_of(coin_sel_q);
                        dispensed_q <= dispensed_q + denom_of(coin_sel_q);
                        if (stock_q[coin_sel_q] != '0) begin
                            stock_q[coin_sel_q] <= stock_q[coin_sel_q] - STOCK_W'(1);
                        end
                        coin_req_q <= 1'b0;
                        state_q    <= StSelect;
                    end else if (cnt_q == CNT_LAST) begin
                        jammed_q[coin_sel_q] <= 1'b1;
                        coin_req_q           <= 1'b0;
                        state_q              <= StSelect;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StFinish: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.coin_req        = coin_req_q;
    assign bus.coin_sel        = coin_sel_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.dispensed_total = dispensed_q;
    assign bus.shortfall       = shortfall_q;
    assign bus.stock_level     = stock_level;
    assign bus.jammed          = jammed_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: two instances (stock 8 and stock 1) share stimulus
// and are checked against a greedy payout model.
module tb_change_dispenser;
    import change_dispenser_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    change_dispenser_if #(.STOCK_W(4)) bus0 ();
    change_dispenser_if #(.STOCK_W(4)) bus1 ();

    change_dispenser #(.STOCK_W(4), .STOCK_INIT(8), .ACK_TIMEOUT(15)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    change_dispenser #(.STOCK_W(4), .STOCK_INIT(1), .ACK_TIMEOUT(15)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int         checks = 0;
    int         errors = 0;
    logic [3:0] block_mask = 4'h0;
    int         ack_delay = 1;
    int         got0[$];
    int         got1[$];
    int         jam_run0 = 0;
    bit         done0, done1;
    int         tot0, tot1, sh0, sh1;

    int denom[4]      = '{10, 5, 2, 1};
    int init_stock[2] = '{8, 1};
    int m_stock[2][4];
    bit m_jam[2][4];
    int exp_seq0[$];
    int exp_seq1[$];
    int exp_tot[2];
    int exp_sh[2];
    bit exp_first[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hopper model for instance 0: acks after ack_delay cycles unless the type is blocked.
    initial begin
        int d, run;
        d = 0; run = 0;
        bus0.coin_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus0.coin_ack) begin
                bus0.coin_ack = 1'b0;
                d = 0;
            end else if (bus0.coin_req) begin
                if (block_mask[bus0.coin_sel]) run++;
                else if (d >= ack_delay) begin
                    bus0.coin_ack = 1'b1;
                    got0.push_back(int'(bus0.coin_sel));
                end else d++;
            end else begin
                if (run > 0) jam_run0 = run;
                run = 0;
                d = 0;
            end
        end
    end

    initial begin
        int d;
        d = 0;
        bus1.coin_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus1.coin_ack) begin
                bus1.coin_ack = 1'b0;
                d = 0;
            end else if (bus1.coin_req) begin
                if (!block_mask[bus1.coin_sel]) begin
                    if (d >= ack_delay) begin
                        bus1.coin_ack = 1'b1;
                        got1.push_back(int'(bus1.coin_sel));
                    end else d++;
                end
            end else d = 0;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (bus0.done) begin done0 = 1; tot0 = bus0.dispensed_total; sh0 = bus0.shortfall; end
            if (bus1.done) begin done1 = 1; tot1 = bus1.dispensed_total; sh1 = bus1.shortfall; end
        end
    end

    task automatic drive_in(input bit s, input bit r, input int a);
        bus0.start = s; bus1.start = s;
        bus0.refill = r; bus1.refill = r;
        bus0.change_amount = amount_t'(a); bus1.change_amount = amount_t'(a);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                m_stock[k][i] = init_stock[k];
                m_jam[k][i]   = 0;
            end
    endtask

    // Greedy payout: largest fitting coin with stock and no jam; a blocked coin jams its hopper.
    task automatic model_payout(input int k, input int amount, input logic [3:0] blk);
        int rem, pick, n;
        int s[$];
        bit first, stop;
        rem = amount; first = 0; stop = 0; n = 0;
        while (!stop && n < 40) begin
            pick = -1;
            for (int i = 0; i < 4; i++)
                if (pick < 0 && denom[i] <= rem && m_stock[k][i] > 0 && !m_jam[k][i]) pick = i;
            if (pick < 0) stop = 1;
            else begin
                if (n == 0) first = 1;
                if (blk[pick]) m_jam[k][pick] = 1;
                else begin
                    s.push_back(pick);
                    rem -= denom[pick];
                    m_stock[k][pick]--;
                end
            end
            n++;
        end
        exp_tot[k] = amount - rem;
        exp_sh[k] = rem;
        exp_first[k] = first;
        if (k == 0) exp_seq0 = s; else exp_seq1 = s;
    endtask

    function automatic logic [15:0] exp_lvl(input int k);
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[i*4 +: 4] = 4'(m_stock[k][i]);
        return v;
    endfunction

    function automatic logic [3:0] exp_jam(input int k);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_jam[k][i];
        return v;
    endfunction

    task automatic compare_inst(input int k, input int amount);
        int g[$];
        int e[$];
        logic [15:0] lvl;
        logic [3:0] jm;
        int tot, sh;
        if (k == 0) begin
            g = got0; e = exp_seq0; lvl = bus0.stock_level; jm = bus0.jammed; tot = tot0; sh = sh0;
        end else begin
            g = got1; e = exp_seq1; lvl = bus1.stock_level; jm = bus1.jammed; tot = tot1; sh = sh1;
        end
        check($sformatf("n_coins%0d amt=%0d", k, amount), g.size(), e.size());
        for (int i = 0; i < e.size() && i < g.size(); i++)
            check($sformatf("coin%0d[%0d] amt=%0d", k, i, amount), g[i], e[i]);
        check($sformatf("total%0d amt=%0d", k, amount), tot, exp_tot[k]);
        check($sformatf("short%0d amt=%0d", k, amount), sh, exp_sh[k]);
        check($sformatf("sum%0d amt=%0d", k, amount), tot + sh, amount);
        check($sformatf("stock%0d amt=%0d", k, amount), lvl, exp_lvl(k));
        check($sformatf("jammed%0d amt=%0d", k, amount), jm, exp_jam(k));
    endtask

    task automatic do_payout(input int amount, input logic [3:0] blk, input int dly, input bit pulse);
        int cyc;
        block_mask = blk;
        ack_delay = dly;
        got0.delete(); got1.delete();
        done0 = 0; done1 = 0;
        model_payout(0, amount, blk);
        model_payout(1, amount, blk);
        drive_in(1, 0, amount);
        @(posedge clk); #2;
        drive_in(0, 0, 0);
        check("busy_n1_0", bus0.busy, 1);
        check("busy_n1_1", bus1.busy, 1);
        check("req_n1_0", bus0.coin_req, 0);
        @(posedge clk); #2;
        check("req_n2_0", bus0.coin_req, exp_first[0]);
        check("req_n2_1", bus1.coin_req, exp_first[1]);
        check("done_n2_0", bus0.done, !exp_first[0]);
        check("done_n2_1", bus1.done, !exp_first[1]);
        if (pulse) begin
            drive_in(1, 1, 7);
            @(posedge clk); #2;
            drive_in(0, 0, 0);
        end
        cyc = 0;
        while (!(done0 && done1) && cyc < 600) begin
            @(posedge clk); #2;
            cyc++;
        end
        check("done_within_budget", done0 && done1, 1);
        @(posedge clk); #2;
        check("idle_busy0", bus0.busy, 0);
        check("idle_busy1", bus1.busy, 0);
        check("done_pulse0", bus0.done, 0);
        compare_inst(0, amount);
        compare_inst(1, amount);
    endtask

    task automatic do_refill();
        drive_in(0, 1, 0);
        @(posedge clk); #2;
        drive_in(0, 0, 0);
        model_reset();
        check("refill_stock0", bus0.stock_level, exp_lvl(0));
        check("refill_stock1", bus1.stock_level, exp_lvl(1));
        check("refill_jam0", bus0.jammed, 0);
        check("refill_jam1", bus1.jammed, 0);
    endtask

    initial begin
        int cyc, amt, dly;
        logic [3:0] blk;
        reset = 1'b1;
        drive_in(0, 0, 0);
        model_reset();
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_req", bus0.coin_req, 0);
        check("rst_sel", bus0.coin_sel, 0);
        check("rst_busy", bus0.busy, 0);
        check("rst_done", bus0.done, 0);
        check("rst_total", bus0.dispensed_total, 0);
        check("rst_short", bus0.shortfall, 0);
        check("rst_jam", bus0.jammed, 0);
        check("rst_stock0", bus0.stock_level, 16'h8888);
        check("rst_stock1", bus1.stock_level, 16'h1111);
        reset = 1'b1;
        @(posedge clk); #2;

        do_payout(18, 4'h0, 1, 0);
        check("p18_total", tot0, 18);
        check("p18_short", sh0, 0);
        check("p18_stock", bus0.stock_level, 16'h7777);

        do_refill();
        do_payout(31, 4'h0, 1, 0);
        check("p31_total1", tot1, 18);
        check("p31_short1", sh1, 13);
        check("p31_stock1", bus1.stock_level, 16'h0000);

        do_refill();
        do_payout(0, 4'h0, 0, 0);
        check("p0_total", tot0, 0);

        jam_run0 = 0;
        do_payout(5, 4'b0010, 1, 0);
        check("jam_run", jam_run0, 15);
        check("jam_vec", bus0.jammed, 4'b0010);
        check("jam_short", sh0, 0);
        do_refill();
        check("jam_clear_stock", bus0.stock_level, 16'h8888);

        // start and refill pulsed while busy must both be ignored
        do_payout(12, 4'h0, 2, 1);
        check("p12_total", tot0, 12);
        check("p12_stock", bus0.stock_level, 16'h8787);

        for (int it = 0; it < 20; it++) begin
            if (it % 4 == 3) do_refill();
            amt = int'($urandom_range(0, 31));
            blk = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            dly = int'($urandom_range(0, 3));
            do_payout(amt, blk, dly, 0);
        end

        block_mask = 4'hF;
        drive_in(1, 0, 20);
        @(posedge clk); #2;
        drive_in(0, 0, 0);
        cyc = 0;
        while (!bus0.coin_req && cyc < 10) begin
            @(posedge clk); #2;
            cyc++;
        end
        check("mid_req_seen", bus0.coin_req, 1);
        check("mid_busy_seen", bus0.busy, 1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("async_req0", bus0.coin_req, 0);
        check("async_busy0", bus0.busy, 0);
        check("async_req1", bus1.coin_req, 0);
        check("async_busy1", bus1.busy, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        block_mask = 4'h0;
        model_reset();
        @(posedge clk); #2;
        check("post_rst_stock0", bus0.stock_level, 16'h8888);
        check("post_rst_stock1", bus1.stock_level, exp_lvl(1));
        check("post_rst_jam0", bus0.jammed, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Pays out the change computed for a finished transaction as individual coins through a coin-hopper handshake. It latches a 5-bit change value on start and pays it greedily in denominations 10, 5, 2 and 1. It tracks per-denomination stock and jam status, and reports the amount paid and any unpaid shortfall. It sits downstream of the change calculation stage and upstream of the physical hopper interface.

Parameters:
STOCK_W, 4, width of each per-denomination stock counter
STOCK_INIT, 8, stock loaded into every denomination on reset and on refill (must be < 2**STOCK_W)
ACK_TIMEOUT, 15, cycles to wait for coin_ack before declaring the selected hopper jammed

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  one-cycle request to pay out change_amount; honoured only in IDLE
change_amount  input  5  change to pay, in currency units; sampled on an accepted start
refill  input  1  restores all stocks to STOCK_INIT and clears jammed; honoured only in IDLE
coin_ack  input  1  hopper has ejected the requested coin; ignored unless coin_req is high
coin_req  output  1  request one coin of type coin_sel
coin_sel  output  2  coin type: 0=10, 1=5, 2=2, 3=1
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of payout
dispensed_total  output  5  units paid in the current/last payout
shortfall  output  5  units unpaid at end of the last payout
stock_level  output  4*STOCK_W  packed stocks, [STOCK_W-1:0]=10s ... top slice=1s
jammed  output  4  per-denomination jam flags, bit i matches coin_sel i

Behaviour:
- Reset (asynchronous, acts immediately):
  - FSM goes to IDLE.
  - coin_req, coin_sel, busy, done, dispensed_total, shortfall and jammed all go to 0.
  - Every stock is set to STOCK_INIT.
  - The internal remaining register and the timeout counter are cleared.
- FSM states: IDLE, SELECT, DISPENSE, FINISH.
- IDLE:
  - start=1 latches remaining<=change_amount, clears dispensed_total and shortfall, and moves to SELECT.
  - refill=1 with start=0 reloads all stocks and clears jammed.
  - start and refill together: start wins and the refill is dropped.
- SELECT (one cycle): choose the lowest index i whose denomination <= remaining, whose stock != 0 and whose jammed[i]=0.
  - If remaining==0 or no such i exists, go to FINISH.
  - Otherwise register coin_sel<=i, clear the timeout counter and go to DISPENSE.
- DISPENSE:
  - coin_req=1 and coin_sel is held stable.
  - On coin_ack=1: remaining -= denom, dispensed_total += denom, stock[i] -= 1, coin_req drops the next cycle, return to SELECT.
  - If ACK_TIMEOUT cycles pass without ack: jammed[i]<=1, coin_req drops, return to SELECT. Stock and totals are unchanged.
  - An ack that arrives in the same cycle the timeout expires is treated as an ack.
- FINISH (one cycle): shortfall<=remaining, done=1, then go to IDLE.
- Latency:
  - start in cycle N gives busy and SELECT in N+1.
  - First coin_req is asserted in N+2.
  - An amount of 0 gives done in N+2.
  - Each acknowledged coin costs its ack cycle plus one SELECT cycle.
- Arithmetic:
  - All payout arithmetic is 5-bit unsigned; remaining never underflows because of the selection rule.
  - dispensed_total + shortfall == latched change_amount at done.
  - Stocks saturate at 0 and are never decremented below zero.
- Ignored inputs: start and refill while busy; coin_ack in any state other than DISPENSE.
- Reset asserted mid-DISPENSE drops coin_req asynchronously; the payout is lost and stocks return to STOCK_INIT.
- Outputs dispensed_total, shortfall and jammed hold their values in IDLE until the next start, refill or reset.

Decomposition:
- Shared package holds:
  - coin-type encoding constants COIN_10=0, COIN_5=1, COIN_2=2, COIN_1=3;
  - denomination lookup values 10/5/2/1;
  - the FSM state encoding;
  - the amount width constant of 5 bits, shared with the change calculation stage.
- One natural sub-module, coin_selector: a combinational priority pick of the largest eligible denomination from remaining, the stock-nonzero vector and jammed. It outputs a valid flag and the index.
- FSM, counters and the handshake stay in change_dispenser.

Test Plan:
- Reset, start with change_amount=18, ack each request 1 cycle after coin_req:
  - coin_sel sequence is 0,1,2,3;
  - done with dispensed_total=18, shortfall=0;
  - every stock ends at 7.
- Start with change_amount=0: no coin_req; done pulses exactly 2 cycles after start; both totals 0.
- Build with STOCK_INIT=1, start with 31, ack every request:
  - coins 10,5,2,1 are paid;
  - dispensed_total=18, shortfall=13;
  - all stocks end at 0.
- Start with 5 and never ack type 1:
  - coin_req drops after 15 cycles and jammed=4'b0010;
  - then coins 2,2,1 are paid;
  - shortfall=0;
  - a following refill in IDLE clears jammed and restores stocks to 8.
- Assert reset during DISPENSE:
  - coin_req and busy go to 0 in the same cycle, without waiting for a clock edge;
  - after release, stock_level shows 8 in every slice.
- Pulse start=1 (amount 7) and refill=1 while busy paying 12: both are ignored; the 12 payout completes normally and stocks are not reloaded.
